// File: rtl/hsv_pkg.sv
// Shared constants and types for the HSV pipeline.
// Hue offsets are in degrees.
package hsv_pkg;

    localparam int HUE_SCALE    = 60;
    localparam int HUE_G_OFFSET = 120;
    localparam int HUE_B_OFFSET = 240;
    localparam int HUE_FULL     = 360;

    typedef enum logic [1:0] {
        FUNC_NONE  = 2'd0,
        FUNC_RED   = 2'd1,
        FUNC_GREEN = 2'd2,
        FUNC_BLUE  = 2'd3
    } hsv_func_t;

endpackage

// File: rtl/hue_div_stage.sv
// One registered restoring-division iteration. It resolves quotient bit BIT_IDX
// and carries the sample's sideband alongside it.
module hue_div_stage
    import hsv_pkg::*;
#(
    parameter int DATA_W  = 9,
    parameter int Q_W     = 6,
    parameter int REM_W   = DATA_W + Q_W,
    parameter int BIT_IDX = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [REM_W-1:0]  i_rem,
    input  logic [DATA_W-1:0] i_div,
    input  logic [Q_W-1:0]    i_quot,
    input  logic              i_sign,
    input  hsv_func_t         i_func,
    input  logic [DATA_W-1:0] i_value,
    input  logic              i_valid,
    output logic [REM_W-1:0]  o_rem,
    output logic [DATA_W-1:0] o_div,
    output logic [Q_W-1:0]    o_quot,
    output logic              o_sign,
    output hsv_func_t         o_func,
    output logic [DATA_W-1:0] o_value,
    output logic              o_valid
);

    logic [REM_W-1:0]  shifted;
    logic              take;
    logic [REM_W-1:0]  rem_d,   rem_q;
    logic [Q_W-1:0]    quot_d,  quot_q;
    logic [DATA_W-1:0] div_q;
    logic              sign_q;
    hsv_func_t         func_q;
    logic [DATA_W-1:0] value_q;
    logic              valid_q;

    always_comb begin
        shifted         = REM_W'(i_div) << BIT_IDX;
        take            = (i_rem >= shifted);
        rem_d           = take ? (i_rem - shifted) : i_rem;
        quot_d          = i_quot;
        quot_d[BIT_IDX] = take;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rem_q   <= '0;
            div_q   <= '0;
            quot_q  <= '0;
            sign_q  <= 1'b0;
            func_q  <= FUNC_NONE;
            value_q <= '0;
            valid_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            div_q   <= i_div;
            quot_q  <= quot_d;
            sign_q  <= i_sign;
            func_q  <= i_func;
            value_q <= i_value;
            valid_q <= i_valid;
        end
    end

    assign o_rem   = rem_q;
    assign o_div   = div_q;
    assign o_quot  = quot_q;
    assign o_sign  = sign_q;
    assign o_func  = func_q;
    assign o_value = value_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/hsv_hue_divider.sv
// Pipelined hue stage: prep register, Q_W restoring-divider stages, hue assembly register.
// Sample flow is valid-only. Every i_valid cycle is accepted, and o_valid follows it Q_W+2 clocks later; there is no backpressure.
module hsv_hue_divider
    import hsv_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int Q_W    = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_delta,
    input  logic [1:0]        i_function,
    input  logic [DATA_W-1:0] i_value,
    input  logic              i_valid,
    output logic [DATA_W-1:0] o_hue,
    output logic [DATA_W-1:0] o_value,
    output logic              o_valid
);

    // 60 < 2**6, so 60*m always fits in DATA_W+6 bits.
    localparam int NUM_W = DATA_W + Q_W;

    logic [NUM_W-1:0]  rem_s   [Q_W+1];
    logic [DATA_W-1:0] div_s   [Q_W+1];
    logic [Q_W-1:0]    quot_s  [Q_W+1];
    logic              sign_s  [Q_W+1];
    hsv_func_t         func_s  [Q_W+1];
    logic [DATA_W-1:0] value_s [Q_W+1];
    logic              valid_s [Q_W+1];

    logic              sign_d;
    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] mag_clamped;
    logic [NUM_W-1:0]  num_d,   num_q;
    hsv_func_t         func_d,  func_q;
    logic              sign_q;
    logic [DATA_W-1:0] div_q;
    logic [DATA_W-1:0] value_q;
    logic              valid_q;

    // Clamping m to D saturates q at 60; zero delta is folded into FUNC_NONE.
    always_comb begin
        sign_d      = i_dividend[DATA_W-1];
        mag         = sign_d ? (~i_dividend + DATA_W'(1)) : i_dividend;
        mag_clamped = (mag > i_delta) ? i_delta : mag;
        num_d       = NUM_W'(mag_clamped) * NUM_W'(HUE_SCALE);
        func_d      = (i_delta == '0) ? FUNC_NONE : hsv_func_t'(i_function);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            num_q   <= '0;
            div_q   <= '0;
            sign_q  <= 1'b0;
            func_q  <= FUNC_NONE;
            value_q <= '0;
            valid_q <= 1'b0;
        end else begin
            num_q   <= num_d;
            div_q   <= i_delta;
            sign_q  <= sign_d;
            func_q  <= func_d;
            value_q <= i_value;
            valid_q <= i_valid;
        end
    end

    assign rem_s[0]   = num_q;
    assign div_s[0]   = div_q;
    assign quot_s[0]  = '0;
    assign sign_s[0]  = sign_q;
    assign func_s[0]  = func_q;
    assign value_s[0] = value_q;
    assign valid_s[0] = valid_q;

    for (genvar k = 1; k <= Q_W; k++) begin : g_stage
        hue_div_stage #(
            .DATA_W (DATA_W),
            .Q_W    (Q_W),
            .REM_W  (NUM_W),
            .BIT_IDX(Q_W - k)
        ) u_stage (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_rem  (rem_s[k-1]),
            .i_div  (div_s[k-1]),
            .i_quot (quot_s[k-1]),
            .i_sign (sign_s[k-1]),
            .i_func (func_s[k-1]),
            .i_value(value_s[k-1]),
            .i_valid(valid_s[k-1]),
            .o_rem  (rem_s[k]),
            .o_div  (div_s[k]),
            .o_quot (quot_s[k]),
            .o_sign (sign_s[k]),
            .o_func (func_s[k]),
            .o_value(value_s[k]),
            .o_valid(valid_s[k])
        );
    end

    logic unused_tail;
    assign unused_tail = ^{rem_s[Q_W], div_s[Q_W]};

    logic [DATA_W-1:0] q_ext;
    logic [DATA_W-1:0] hue_d, hue_q;
    logic [DATA_W-1:0] out_value_q;
    logic              out_valid_q;

    always_comb begin
        hue_d = '0;
        q_ext = DATA_W'(quot_s[Q_W]);
        case (func_s[Q_W])
            FUNC_RED: begin
                if (!sign_s[Q_W])
                    hue_d = q_ext;
                else if (q_ext != '0)
                    hue_d = DATA_W'(HUE_FULL) - q_ext;
            end
            FUNC_GREEN: hue_d = sign_s[Q_W] ? DATA_W'(HUE_G_OFFSET) - q_ext
                                            : DATA_W'(HUE_G_OFFSET) + q_ext;
            FUNC_BLUE:  hue_d = sign_s[Q_W] ? DATA_W'(HUE_B_OFFSET) - q_ext
                                            : DATA_W'(HUE_B_OFFSET) + q_ext;
            default:    hue_d = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hue_q       <= '0;
            out_value_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            hue_q       <= hue_d;
            out_value_q <= value_s[Q_W];
            out_valid_q <= valid_s[Q_W];
        end
    end

    assign o_hue   = hue_q;
    assign o_value = out_value_q;
    assign o_valid = out_valid_q;

endmodule

// File: tb/tb_hsv_hue_divider.sv
// Randomised and directed bench for hsv_hue_divider.
// Outputs are checked in order against an arithmetic hue model.
module tb_hsv_hue_divider;

    localparam int DW  = 9;
    localparam int LAT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] dividend;
    logic [DW-1:0] delta;
    logic [1:0]    fn;
    logic [DW-1:0] value;
    logic          valid;
    logic [DW-1:0] o_hue;
    logic [DW-1:0] o_value;
    logic          o_valid;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [31:0]   due;
        logic [DW-1:0] hue;
        logic [DW-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hsv_hue_divider #(.DATA_W(DW), .Q_W(6)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_dividend(dividend),
        .i_delta   (delta),
        .i_function(fn),
        .i_value   (value),
        .i_valid   (valid),
        .o_hue     (o_hue),
        .o_value   (o_value),
        .o_valid   (o_valid)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Hue in degrees from the signed difference, delta and max-channel code.
    function automatic int ref_hue(input logic [DW-1:0] dvd, input logic [DW-1:0] dlt,
                                   input logic [1:0] f);
        int m, d, q, sq;
        m = dvd[DW-1] ? (1 << DW) - int'(dvd) : int'(dvd);
        d = int'(dlt);
        if (f == 2'd0 || d == 0) return 0;
        q  = (m > d) ? 60 : (60 * m) / d;
        sq = dvd[DW-1] ? -q : q;
        case (f)
            2'd1:    return (sq < 0) ? 360 + sq : sq;
            2'd2:    return 120 + sq;
            default: return 240 + sq;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [DW-1:0] dvd, input logic [DW-1:0] dlt,
                         input logic [1:0] f, input logic [DW-1:0] val, input int exp_hue);
        exp_t e;
        @(posedge clk);
        #1;
        valid    = v;
        dividend = dvd;
        delta    = dlt;
        fn       = f;
        value    = val;
        if (v) begin
            e.due = 32'(cyc + LAT);
            e.hue = DW'(exp_hue);
            e.val = val;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 2'd0, '0, 0);
    endtask

    task automatic send_rand();
        int dlt, m, s, dv;
        logic [DW-1:0] dvd;
        logic [1:0]    f;
        dlt = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 511));
        s   = int'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) m = int'($urandom_range(0, 256));
        else                           m = int'($urandom_range(0, (dlt > 256) ? 256 : dlt));
        if (!s && m > 255) m = 255;
        dv  = s ? ((1 << DW) - m) % (1 << DW) : m;
        dvd = DW'(dv);
        f   = 2'($urandom_range(0, 3));
        drive(1'b1, dvd, DW'(dlt), f, DW'($urandom_range(0, 511)), ref_hue(dvd, DW'(dlt), f));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("stale_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("latency", cyc, int'(mon_e.due));
                    check("hue", int'(o_hue), int'(mon_e.hue));
                    check("value", int'(o_value), int'(mon_e.val));
                end
            end else if (exp_q.size() > 0 && int'(exp_q[0].due) <= cyc) begin
                check("missing_valid", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        check("timeout", 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b0; valid = 1'b0; dividend = '0; delta = '0; fn = '0; value = '0;
        #1 rst = 1'b1;
        #2;
        check("reset_valid", int'(o_valid), 0);
        check("reset_hue", int'(o_hue), 0);
        check("reset_value", int'(o_value), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed points, issued back to back.
        drive(1'b1, 9'd128, 9'd248, 2'd1, 9'd17,  30);
        drive(1'b1, 9'd392, 9'd248, 2'd1, 9'd200, 331);
        drive(1'b1, 9'd0,   9'd248, 2'd1, 9'd5,   0);
        drive(1'b1, 9'd96,  9'd252, 2'd2, 9'd300, 142);
        drive(1'b1, 9'd312, 9'd248, 2'd3, 9'd64,  192);
        drive(1'b1, 9'd248, 9'd248, 2'd3, 9'd511, 300);
        drive(1'b1, 9'd100, 9'd200, 2'd0, 9'd9,   0);
        drive(1'b1, 9'd100, 9'd0,   2'd2, 9'd77,  0);
        drive(1'b1, 9'd250, 9'd10,  2'd1, 9'd33,  60);
        drive(1'b1, 9'd256, 9'd255, 2'd2, 9'd1,   60);
        idle(LAT + 2);

        // Isolated sample for a clean latency measurement.
        drive(1'b1, 9'd128, 9'd248, 2'd1, 9'd42, 30);
        idle(LAT + 2);

        for (int i = 0; i < 20; i++) send_rand();
        idle(3);
        for (int i = 0; i < 5; i++) send_rand();
        idle(LAT + 2);

        // Reset with six samples still in flight.
        for (int i = 0; i < 6; i++) send_rand();
        idle(4);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_valid", int'(o_valid), 0);
        check("midrst_hue", int'(o_hue), 0);
        check("midrst_value", int'(o_value), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, 9'd96, 9'd252, 2'd2, 9'd123, 142);
        idle(LAT + 6);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        check("drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hsv_hue_divider.md
# hsv_hue_divider

Pipelined hue stage placed directly downstream of the HSV decoder. It consumes the decoder's signed dividend, delta, max-channel function code and V value. It computes hue in degrees (0..359) with a fully pipelined restoring divider, accepting one sample per clock and producing results in input order. The value channel is carried alongside the hue so the next stage receives hue and value aligned.

## Interface
- `DATA_W`, default 9: width of dividend, delta, value and hue.
- `Q_W`, default 6: quotient width, which is also the number of divider stages (q ≤ 60).
- `i_clk`, input, 1: clock.
- `i_rst`, input, 1: reset, asynchronous and active-high.
- `i_dividend`, input, `DATA_W`: signed two's-complement channel difference from the decoder.
- `i_delta`, input, `DATA_W`: unsigned max − min.
- `i_function`, input, 2: max-channel code. 0 = none/grey, 1 = red, 2 = green, 3 = blue.
- `i_value`, input, `DATA_W`: V, passed through untouched.
- `i_valid`, input, 1: sample qualifier. There is no backpressure.
- `o_hue`, output, `DATA_W`: hue in degrees, 0..359.
- `o_value`, output, `DATA_W`: `i_value` delayed to align with `o_hue`.
- `o_valid`, output, 1: one-cycle qualifier per accepted sample.

## Operation
- Every cycle with `i_valid` = 1 is a sample. There is no ready signal and no sample is ever dropped.
- Stage 0 registers the following:
  - sign s = `i_dividend`[`DATA_W`-1];
  - magnitude m = |`i_dividend`|, kept 9 bits wide so that m = 256 is representable;
  - numerator N = 60·m, 15 bits;
  - divisor D = `i_delta`;
  - `i_function`, `i_value`, and `i_valid`.
- Stages 1..`Q_W` each run one restoring iteration and resolve quotient bit `Q_W`−k, MSB first:
  - if the remainder ≥ D << (`Q_W`−k), subtract it and set the bit;
  - otherwise keep the remainder and clear the bit.
- Result: q = floor(60·m / D), truncated toward zero. If m > D (out-of-contract input), q saturates to 60.
- The final stage assembles the hue from the signed quotient sq = s ? −q : q:
  - function 1: s = 0 gives q; s = 1 gives 360 − q, or 0 when q = 0.
  - function 2: 120 + sq, range 60..180.
  - function 3: 240 + sq, range 180..300.
  - function 0 or D = 0: hue = 0, which also avoids divide-by-zero.
- `o_value` is the `i_value` of the same sample, unchanged.

## Timing
- Latency: `Q_W` + 2 = 8 clocks. A sample presented at edge E0 appears with `o_valid` = 1 after edge E8.
- Throughput: one sample per clock. Back-to-back inputs give back-to-back outputs in strict FIFO order.
- `o_valid` and `i_valid` map 1:1. Gaps in the input are reproduced exactly.
- `o_hue` and `o_value` are registered. When `o_valid` = 0 they hold their last value and carry no meaning.
- Data registers may be clocked unconditionally; only the valid chain must be exact.
- Reset:
  - All valid bits, `o_valid`, `o_hue` and `o_value` go to 0 immediately (asynchronous).
  - Samples in flight are discarded, so no `o_valid` appears for pre-reset inputs.
  - The first sample accepted after reset deasserts emerges 8 clocks later.
- Simultaneous input and output in the same cycle is the normal pipelined case and needs no special handling.

## Structure
- Shared package `hsv_pkg` holds:
  - `HUE_SCALE` = 60, `HUE_G_OFFSET` = 120, `HUE_B_OFFSET` = 240, `HUE_FULL` = 360;
  - enum `hsv_func_t` with values `FUNC_NONE`, `FUNC_RED`, `FUNC_GREEN`, `FUNC_BLUE` (0..3).
- Sub-module `hue_div_stage` implements one registered restoring iteration:
  - inputs: remainder, divisor, partial quotient, and sideband (sign, function, value, valid);
  - parameter: bit index.
- The top instantiates `hue_div_stage` `Q_W` times in a generate loop, between the stage-0 prep registers and the hue-assembly register.

## Test plan
- Red max, positive: dividend = 128, delta = 248, fn = 1 → hue 30, `o_valid` exactly 8 clocks after input.
- Red max, negative: dividend = −120, delta = 248, fn = 1 → q = 29, hue 331. Also dividend = 0, fn = 1 → hue 0, not 360.
- Green and blue: dividend = 96, delta = 252, fn = 2 → hue 142. Dividend = −200, delta = 248, fn = 3 → hue 192. Dividend = 248, delta = 248, fn = 3 → hue 300.
- Grey and guard cases:
  - fn = 0 with any operands → hue 0;
  - fn = 2 with delta = 0 → hue 0;
  - dividend = 250, delta = 10, fn = 1 → hue 60 (saturated).
- Streaming: 20 consecutive random samples, then a 3-cycle gap, then 5 more. Check outputs against a reference model in order, with an identical valid pattern delayed by 8 cycles and `o_value` matching each sample.
- Reset mid-flight: assert `i_rst` 4 cycles after issuing 6 samples → `o_valid` = 0 and outputs = 0 at once, and no stale outputs appear afterwards. One sample issued after release emerges 8 clocks later.
